// File: rtl/console_adc_seq.sv
// console_adc_seq: conf/conv transaction sequencer fanning a send/wait/read handshake out to N_ADC links,
// capturing per-channel temp/type on conf and flagging channels that stall a phase.
module console_adc_seq #(
  parameter int N_ADC = 8,
  parameter int STAT_W = 32,
  parameter int TO_W = 16,
  parameter int TO_MAX = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fs_adc_conf,
  output logic                      fd_adc_conf,
  input  logic                      fs_adc_conv,
  output logic                      fd_adc_conv,
  output logic                      fs_send,
  input  logic [N_ADC-1:0]          fd_send,
  input  logic [N_ADC-1:0]          fs_read,
  output logic                      fd_read,
  output logic [3:0]                send_btype,
  output logic [3:0]                read_btype,
  input  logic [15:0]               com_cmd,
  input  logic [N_ADC*STAT_W-1:0]   cache_stat,
  input  logic [N_ADC-1:0]          adc_stat,
  output logic [16+10*N_ADC-1:0]    adc_info,
  output logic [N_ADC-1:0]          err_timeout,
  output logic                      busy
);
  typedef enum logic [2:0] {MAIN_IDLE, MAIN_WAIT, X_IDLE, X_WORK, X_WAIT, X_READ, X_DONE, MAIN_DONE} state_t;
  state_t state, next;
  logic mode, first, phase, timeout;
  logic [TO_W-1:0] cnt;
  logic [N_ADC-1:0] to_err, act, pend;
  logic [15:0] adc_conf;
  logic [2*N_ADC-1:0] type_r;
  logic [8*N_ADC-1:0] temp_r;
  logic unused_ok;
  function automatic logic [1:0] type_map(input logic [7:0] b);
    return b == 8'h55 ? 2'b01 : b == 8'hAA ? 2'b10 : b == 8'hFF ? 2'b11 : 2'b00;
  endfunction
  assign unused_ok = ^cache_stat;
  assign act = adc_stat & ~to_err;
  assign adc_info = {adc_conf, type_r, temp_r};
  assign phase = state inside {X_WORK, X_WAIT, X_READ};
  assign timeout = phase && |pend && cnt == TO_W'(TO_MAX - 1);
  always_comb begin
    for (int i = 0; i < N_ADC; i++) err_timeout[N_ADC-1-i] = to_err[i];
  end
  always_comb begin
    next = state;
    fs_send = 1'b0;
    fd_read = 1'b0;
    fd_adc_conf = 1'b0;
    fd_adc_conv = 1'b0;
    pend = '0;
    busy = state != MAIN_WAIT;
    case (state)
      MAIN_IDLE: next = MAIN_WAIT;
      MAIN_WAIT: next = (fs_adc_conf || fs_adc_conv) ? X_IDLE : MAIN_WAIT;
      X_IDLE:    next = X_WORK;
      X_WORK: begin
        fs_send = 1'b1;
        pend = act & ~fd_send;
        next = !(|pend) ? X_WAIT : timeout ? X_DONE : X_WORK;
      end
      X_WAIT: begin
        pend = act & ~fs_read;
        next = !(|pend) ? X_READ : timeout ? X_DONE : X_WAIT;
      end
      X_READ: begin
        fd_read = 1'b1;
        pend = act & fs_read;
        next = (!(|pend) || timeout) ? X_DONE : X_READ;
      end
      X_DONE: begin
        fd_adc_conf = mode;
        fd_adc_conv = !mode;
        next = (mode ? fs_adc_conf : fs_adc_conv) ? X_DONE : MAIN_DONE;
      end
      MAIN_DONE: next = MAIN_WAIT;
      default:   next = MAIN_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MAIN_IDLE;
      mode <= 1'b0;
      first <= 1'b0;
      cnt <= '0;
      to_err <= '0;
      send_btype <= 4'h0;
      read_btype <= 4'h0;
      adc_conf <= '0;
      type_r <= '0;
      temp_r <= '0;
    end else begin
      state <= next;
      cnt <= (next != state) ? '0 : phase ? cnt + 1'b1 : cnt;
      first <= next == X_DONE && state != X_DONE;
      if (state == MAIN_WAIT) mode <= fs_adc_conf;
      if (state == X_IDLE) begin
        to_err <= '0;
        send_btype <= mode ? 4'h6 : 4'h5;
        read_btype <= mode ? 4'hA : (read_btype == 4'hD ? 4'hE : 4'hD);
      end
      if (timeout) to_err <= to_err | pend;
      // capture once, with timed-out channels already excluded from act
      if (state == X_DONE && first && mode) begin
        adc_conf <= com_cmd;
        for (int i = 0; i < N_ADC; i++) begin
          temp_r[(N_ADC-1-i)*8 +: 8] <= act[i] ? cache_stat[(N_ADC-1-i)*STAT_W +: 8] : 8'h00;
          type_r[(N_ADC-1-i)*2 +: 2] <= act[i] ? type_map(cache_stat[(N_ADC-1-i)*STAT_W+8 +: 8]) : 2'b00;
        end
      end
    end
  end
endmodule
